// File: rtl/mips_core_pkg.sv
// mips_core_pkg: shared core widths and ALU control encoding.
package mips_core_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int TAG_WIDTH = 4;
  typedef enum logic [3:0] {
    ALUCTL_NOP, ALUCTL_ADD, ALUCTL_ADDU, ALUCTL_SUB, ALUCTL_SUBU,
    ALUCTL_AND, ALUCTL_OR, ALUCTL_XOR, ALUCTL_NOR, ALUCTL_SLT,
    ALUCTL_SLTU, ALUCTL_SLL, ALUCTL_SRL, ALUCTL_SRA, ALUCTL_LUI
  } alu_ctl_t;
endpackage

// File: rtl/reserv_stat_alu_ifc.sv
// reserv_stat_alu_ifc: issue channel from reservation station to ALU.
interface reserv_stat_alu_ifc #(parameter int TAG_WIDTH = mips_core_pkg::TAG_WIDTH);
  import mips_core_pkg::*;
  logic valid;
  alu_ctl_t alu_ctl;
  logic [DATA_WIDTH-1:0] op1;
  logic [DATA_WIDTH-1:0] op2;
  logic [TAG_WIDTH-1:0] tag;
  modport out (output valid, alu_ctl, op1, op2, tag);
  modport in (input valid, alu_ctl, op1, op2, tag);
endinterface

// File: rtl/rs_select.sv
// rs_select: priority encoder returning the lowest set request index.
module rs_select #(
  parameter int DEPTH = 4
) (
  input  logic [DEPTH-1:0] req,
  output logic [$clog2(DEPTH)-1:0] idx,
  output logic found
);
  localparam int IW = $clog2(DEPTH);
  always_comb begin
    idx = '0;
    found = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = IW'(i);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/alu_reservation_station.sv
// alu_reservation_station: collapsing-queue ALU reservation station with CDB wakeup
// and oldest-ready issue.
module alu_reservation_station
  import mips_core_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_WIDTH = mips_core_pkg::TAG_WIDTH
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic disp_valid,
  output logic disp_ready,
  input  alu_ctl_t disp_alu_ctl,
  input  logic [DATA_WIDTH-1:0] disp_op1,
  input  logic [DATA_WIDTH-1:0] disp_op2,
  input  logic disp_op1_rdy,
  input  logic disp_op2_rdy,
  input  logic [TAG_WIDTH-1:0] disp_op1_tag,
  input  logic [TAG_WIDTH-1:0] disp_op2_tag,
  input  logic [TAG_WIDTH-1:0] disp_tag,
  input  logic cdb_valid,
  input  logic [TAG_WIDTH-1:0] cdb_tag,
  input  logic [DATA_WIDTH-1:0] cdb_result,
  reserv_stat_alu_ifc.out issue
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  typedef struct packed {
    alu_ctl_t alu_ctl;
    logic [DATA_WIDTH-1:0] op1;
    logic [DATA_WIDTH-1:0] op2;
    logic op1_rdy;
    logic op2_rdy;
    logic [TAG_WIDTH-1:0] op1_tag;
    logic [TAG_WIDTH-1:0] op2_tag;
    logic [TAG_WIDTH-1:0] tag;
  } rs_entry_t;
  rs_entry_t ent [DEPTH];
  rs_entry_t woke [DEPTH];
  rs_entry_t nxt [DEPTH];
  rs_entry_t new_ent;
  logic [CW-1:0] count;
  logic [CW-1:0] post;
  logic [DEPTH-1:0] req;
  logic [IW-1:0] sel;
  logic found;
  logic accept;
  // Only operands still waiting compare tags; the dispatch bypass reuses this.
  function automatic rs_entry_t wake(input rs_entry_t e, input logic v,
                                     input logic [TAG_WIDTH-1:0] t,
                                     input logic [DATA_WIDTH-1:0] r);
    rs_entry_t w;
    w = e;
    if (v && !w.op1_rdy && w.op1_tag == t) begin
      w.op1 = r;
      w.op1_rdy = 1'b1;
    end
    if (v && !w.op2_rdy && w.op2_tag == t) begin
      w.op2 = r;
      w.op2_rdy = 1'b1;
    end
    return w;
  endfunction
  assign disp_ready = count < CW'(DEPTH);
  assign accept = disp_valid && disp_ready && !flush;
  assign post = count - CW'(found);
  always_comb begin
    new_ent = wake('{alu_ctl: disp_alu_ctl, op1: disp_op1, op2: disp_op2,
                     op1_rdy: disp_op1_rdy, op2_rdy: disp_op2_rdy,
                     op1_tag: disp_op1_tag, op2_tag: disp_op2_tag, tag: disp_tag},
                   cdb_valid, cdb_tag, cdb_result);
    for (int i = 0; i < DEPTH; i++) begin
      req[i] = (i < int'(count)) && ent[i].op1_rdy && ent[i].op2_rdy;
      woke[i] = wake(ent[i], cdb_valid, cdb_tag, cdb_result);
    end
  end
  rs_select #(.DEPTH(DEPTH)) u_select (.req(req), .idx(sel), .found(found));
  // Entries above the issued slot shift down; the new entry lands at the post-collapse tail.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      nxt[i] = (found && i >= int'(sel)) ? woke[(i < DEPTH - 1) ? i + 1 : i] : woke[i];
      if (accept && i == int'(post)) nxt[i] = new_ent;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
    end else if (flush) begin
      count <= '0;
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
    end else begin
      count <= post + CW'(accept);
      for (int i = 0; i < DEPTH; i++) ent[i] <= nxt[i];
    end
  end
  assign issue.valid = found;
  assign issue.alu_ctl = found ? ent[sel].alu_ctl : ALUCTL_NOP;
  assign issue.op1 = found ? ent[sel].op1 : '0;
  assign issue.op2 = found ? ent[sel].op2 : '0;
  assign issue.tag = found ? ent[sel].tag : '0;
endmodule

// File: tb/tb_alu_reservation_station.sv
// tb_alu_reservation_station: directed and random checks against a queue-based model.
module tb_alu_reservation_station;
  import mips_core_pkg::*;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst, flush, disp_valid, disp_ready, disp_op1_rdy, disp_op2_rdy, cdb_valid;
  alu_ctl_t disp_alu_ctl;
  logic [31:0] disp_op1, disp_op2, cdb_result;
  logic [3:0] disp_op1_tag, disp_op2_tag, disp_tag, cdb_tag;
  int errs = 0;
  int checks = 0;
  typedef struct {
    alu_ctl_t ctl;
    logic [31:0] v1, v2;
    bit r1, r2;
    logic [3:0] t1, t2, tag;
  } m_t;
  m_t q[$];
  reserv_stat_alu_ifc ifc ();
  alu_reservation_station #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush), .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_alu_ctl(disp_alu_ctl), .disp_op1(disp_op1), .disp_op2(disp_op2),
    .disp_op1_rdy(disp_op1_rdy), .disp_op2_rdy(disp_op2_rdy),
    .disp_op1_tag(disp_op1_tag), .disp_op2_tag(disp_op2_tag), .disp_tag(disp_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_result(cdb_result), .issue(ifc)
  );
  always #5 clk = ~clk;

  task automatic check(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h at %0t", n, got, exp, $time);
    end
  endtask

  function automatic m_t wk(input m_t e);
    m_t w = e;
    if (cdb_valid && !w.r1 && w.t1 == cdb_tag) begin w.v1 = cdb_result; w.r1 = 1; end
    if (cdb_valid && !w.r2 && w.t2 == cdb_tag) begin w.v2 = cdb_result; w.r2 = 1; end
    return w;
  endfunction

  task automatic model_next();
    m_t n;
    int s = -1;
    bit acc;
    if (rst || flush) begin
      q.delete();
      return;
    end
    foreach (q[i]) if (s < 0 && q[i].r1 && q[i].r2) s = i;
    acc = disp_valid && q.size() < DEPTH;
    n.ctl = disp_alu_ctl; n.v1 = disp_op1; n.v2 = disp_op2;
    n.r1 = disp_op1_rdy; n.r2 = disp_op2_rdy;
    n.t1 = disp_op1_tag; n.t2 = disp_op2_tag; n.tag = disp_tag;
    foreach (q[i]) q[i] = wk(q[i]);
    n = wk(n);
    if (s >= 0) q.delete(s);
    if (acc) q.push_back(n);
  endtask

  always @(negedge clk) begin
    int s;
    s = -1;
    if (!rst) foreach (q[i]) if (s < 0 && q[i].r1 && q[i].r2) s = i;
    check("disp_ready", 32'(disp_ready), 32'(rst || q.size() < DEPTH));
    check("issue_valid", 32'(ifc.valid), 32'(s >= 0));
    check("issue_ctl", 32'(ifc.alu_ctl), s >= 0 ? 32'(q[s].ctl) : 32'(ALUCTL_NOP));
    check("issue_op1", ifc.op1, s >= 0 ? q[s].v1 : 32'h0);
    check("issue_op2", ifc.op2, s >= 0 ? q[s].v2 : 32'h0);
    check("issue_tag", 32'(ifc.tag), s >= 0 ? 32'(q[s].tag) : 32'h0);
  end

  task automatic tick();
    @(posedge clk);
    model_next();
    #1;
  endtask

  task automatic idle();
    flush = 0; disp_valid = 0; cdb_valid = 0;
  endtask

  task automatic disp(input alu_ctl_t c, input logic [31:0] a, input logic [31:0] b,
                      input bit ra, input bit rb, input logic [3:0] ta,
                      input logic [3:0] tb, input logic [3:0] t);
    disp_valid = 1; disp_alu_ctl = c; disp_op1 = a; disp_op2 = b;
    disp_op1_rdy = ra; disp_op2_rdy = rb; disp_op1_tag = ta; disp_op2_tag = tb; disp_tag = t;
  endtask

  task automatic cdb(input logic [3:0] t, input logic [31:0] r);
    cdb_valid = 1; cdb_tag = t; cdb_result = r;
  endtask

  task automatic pin(input string n, input bit v, input logic [3:0] t);
    check({n, "_valid"}, 32'(ifc.valid), 32'(v));
    if (v) check({n, "_tag"}, 32'(ifc.tag), 32'(t));
  endtask

  initial begin
    rst = 1; idle();
    disp(ALUCTL_NOP, 0, 0, 0, 0, 0, 0, 0); disp_valid = 0;
    cdb_tag = 0; cdb_result = 0;
    tick(); tick();
    check("rst_ready", 32'(disp_ready), 32'd1);
    check("rst_valid", 32'(ifc.valid), 32'd0);
    rst = 0;
    tick();
    // single ready dispatch issues next cycle
    disp(ALUCTL_ADD, 5, 7, 1, 1, 0, 0, 3); tick(); idle();
    pin("add", 1, 3);
    check("add_op1", ifc.op1, 32'd5);
    check("add_op2", ifc.op2, 32'd7);
    check("add_ctl", 32'(ifc.alu_ctl), 32'(ALUCTL_ADD));
    tick(); pin("add_done", 0, 0);
    check("idle_ctl", 32'(ifc.alu_ctl), 32'(ALUCTL_NOP));
    // wakeup from a later broadcast
    disp(ALUCTL_ADD, 0, 1, 0, 1, 2, 0, 5); tick(); idle();
    pin("wait0", 0, 0); tick(); pin("wait1", 0, 0);
    cdb(2, 32'h10); tick(); idle();
    pin("wake", 1, 5);
    check("wake_op1", ifc.op1, 32'h10);
    tick(); pin("wake_done", 0, 0);
    // same-cycle dispatch bypass
    disp(ALUCTL_SUB, 1, 0, 1, 0, 0, 6, 7); cdb(6, 32'hAA); tick(); idle();
    pin("byp", 1, 7);
    check("byp_op2", ifc.op2, 32'hAA);
    tick();
    // fill, full rejection, out-of-order wakeup
    for (int i = 0; i < 4; i++) begin
      disp(ALUCTL_OR, 0, 0, 0, 1, 4'(8 + i), 0, 4'(i + 1)); tick();
    end
    idle();
    check("full_ready", 32'(disp_ready), 32'd0);
    disp(ALUCTL_ADD, 1, 1, 1, 1, 0, 0, 9); tick(); idle();
    pin("full_rej", 0, 0);
    cdb(10, 32'h55); tick(); idle();
    pin("slot2", 1, 3);
    check("slot2_op1", ifc.op1, 32'h55);
    check("slot2_ready", 32'(disp_ready), 32'd0);
    tick();
    check("after_ready", 32'(disp_ready), 32'd1);
    pin("after", 0, 0);
    cdb(9, 32'h1); tick(); cdb(8, 32'h2);
    pin("slot1", 1, 2); tick(); idle();
    pin("slot0", 1, 1); tick();
    pin("gap", 0, 0);
    cdb(11, 32'h3); tick(); idle();
    pin("slot3", 1, 4); tick();
    // two ready entries issue oldest first
    disp(ALUCTL_ADD, 0, 0, 0, 1, 13, 0, 1); tick();
    disp(ALUCTL_SUB, 0, 0, 0, 1, 13, 0, 4); tick(); idle();
    cdb(13, 32'h77); tick(); idle();
    pin("old", 1, 1); tick();
    pin("young", 1, 4); tick();
    pin("pair_done", 0, 0);
    // flush overrides dispatch and wakeup
    for (int i = 0; i < 3; i++) begin
      disp(ALUCTL_AND, 0, 0, 0, 1, 14, 0, 4'(i)); tick();
    end
    flush = 1; disp(ALUCTL_ADD, 1, 1, 1, 1, 0, 0, 9); cdb(14, 32'h9); tick(); idle();
    pin("flush", 0, 0);
    check("flush_ready", 32'(disp_ready), 32'd1);
    tick(); pin("flush2", 0, 0);
    // reset in the middle of traffic
    disp(ALUCTL_ADD, 1, 2, 1, 1, 0, 0, 5); tick();
    disp(ALUCTL_ADD, 3, 4, 1, 1, 0, 0, 6); tick(); idle();
    pin("pre_rst", 1, 6);
    rst = 1; #1;
    pin("in_rst", 0, 0);
    check("in_rst_ready", 32'(disp_ready), 32'd1);
    tick(); rst = 0;
    tick(); pin("post_rst", 0, 0);
    // random traffic
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      flush = ($urandom_range(0, 31) == 0);
      disp_valid = $urandom_range(0, 1) == 1;
      disp_alu_ctl = alu_ctl_t'($urandom_range(0, 14));
      disp_op1 = $urandom; disp_op2 = $urandom;
      disp_op1_rdy = $urandom_range(0, 1) == 1; disp_op2_rdy = $urandom_range(0, 1) == 1;
      disp_op1_tag = 4'($urandom_range(0, 7)); disp_op2_tag = 4'($urandom_range(0, 7));
      disp_tag = 4'($urandom_range(0, 15));
      cdb_valid = $urandom_range(0, 1) == 1;
      cdb_tag = 4'($urandom_range(0, 7)); cdb_result = $urandom;
      tick();
    end
    rst = 0; idle();
    tick();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/alu_reservation_station.md
ALU_RESERVATION_STATION -- requirements
Module: alu_reservation_station

Interface
REQ-001 Parameter DEPTH, default 4, number of entries (2..8).
REQ-002 Parameter TAG_WIDTH, default 4, ROB tag width.
REQ-003 clk  in  1  sole clock, all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 flush  in  1  branch-mispredict squash, synchronous.
REQ-006 disp_valid  in  1  dispatch request.
REQ-007 disp_ready  out  1  space available (not full).
REQ-008 disp_alu_ctl  in  alu_ctl_t  operation.
REQ-009 disp_op1 / disp_op2  in  32 each  operand value when ready.
REQ-010 disp_op1_rdy / disp_op2_rdy  in  1 each  operand value valid.
REQ-011 disp_op1_tag / disp_op2_tag  in  TAG_WIDTH each  producer tag when not ready.
REQ-012 disp_tag  in  TAG_WIDTH  destination ROB tag.
REQ-013 cdb_valid  in  1  result broadcast valid.
REQ-014 cdb_tag  in  TAG_WIDTH  broadcast producer tag.
REQ-015 cdb_result  in  32  broadcast value.
REQ-016 issue  reserv_stat_alu_ifc.out  valid, alu_ctl, op1, op2, tag to ALU.

Function
REQ-017 Entries SHALL form a collapsing queue: slot 0 oldest; occupancy counter 0..DEPTH.
REQ-018 disp_ready SHALL be 1 iff count < DEPTH (no credit for same-cycle issue).
REQ-019 Accepted dispatch (disp_valid & disp_ready & !flush) SHALL write slot at post-collapse tail.
REQ-020 Entry is ready when both operands ready; issue.valid SHALL be combinational: 1 iff any ready entry exists.
REQ-021 Select SHALL pick lowest-index (oldest) ready entry; removed at next edge, younger entries shift down one.
REQ-022 Issue SHALL occur every cycle a ready entry exists (ALU never stalls); latency dispatch-with-ready-operands to issue.valid = 1 cycle.
REQ-023 Wakeup: on cdb_valid, every resident non-ready operand with matching tag SHALL capture cdb_result and set ready at edge; issue eligible next cycle.
REQ-024 Dispatch bypass: if disp_opN not ready and cdb_valid with cdb_tag == disp_opN_tag same cycle, operand SHALL be stored ready with cdb_result.
REQ-025 Simultaneous dispatch + issue: count unchanged; new entry lands at count-1.
REQ-026 flush SHALL clear all entries and count to 0 at next edge; flush overrides dispatch and wakeup; issue.valid still reflects pre-flush contents that cycle (ALU result discarded by ROB).
REQ-027 Ready operands SHALL ignore CDB matches; tags compared only when not ready.
REQ-028 When issue.valid = 0, issue.alu_ctl SHALL be ALUCTL_NOP and op1, op2, tag zero.

Reset
REQ-029 rst SHALL asynchronously clear all valid/ready bits and count; disp_ready = 1, issue.valid = 0 while asserted.
REQ-030 Reset mid-operation SHALL discard all entries; no issue in first cycle after deassertion.

Structure
REQ-031 alu_ctl_t, DATA_WIDTH and TAG_WIDTH default SHALL come from mips_core_pkg; entry struct rs_entry_t local to module.
REQ-032 Oldest-ready select SHALL be a sub-module rs_select (priority encoder, DEPTH-bit request to index plus found).

Verification
REQ-033 Dispatch ADD op1=5 op2=7 both ready, tag 3 -> next cycle issue.valid=1, op1=5, op2=7, tag=3; following cycle issue.valid=0.
REQ-034 Dispatch op1 waiting tag 2; later cdb_valid tag 2 result 0x10 -> issue one cycle after broadcast with op1=0x10.
REQ-035 Dispatch op2 waiting tag 6 while cdb tag 6 result 0xAA same cycle -> issue next cycle with op2=0xAA.
REQ-036 Fill 4 entries all waiting -> disp_ready=0, further disp_valid ignored; wake slot 2 -> it issues, disp_ready=1 following cycle, order of rest preserved.
REQ-037 Two ready entries tags 1 then 4 -> issue tag 1 first, tag 4 next cycle.
REQ-038 flush with 3 entries plus concurrent dispatch -> count 0, no issue next cycle; rst mid-traffic -> same empty state.
